// File: rtl/fsm_leer_rtc_pkg.sv
// fsm_leer_rtc_pkg: state codes, access indices and RTC bus constants shared with the external bus mux
package fsm_leer_rtc_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_GAP    = 3'd4;
    localparam logic PH_ADDR = 1'b0;
    localparam logic PH_DATA = 1'b1;
    localparam logic [3:0] IDX_COM      = 4'd0;
    localparam logic [3:0] IDX_SEG      = 4'd1;
    localparam logic [3:0] IDX_MIN      = 4'd2;
    localparam logic [3:0] IDX_HORA     = 4'd3;
    localparam logic [3:0] IDX_DIA      = 4'd4;
    localparam logic [3:0] IDX_MES      = 4'd5;
    localparam logic [3:0] IDX_ANIO     = 4'd6;
    localparam logic [3:0] IDX_SEG_TIM  = 4'd7;
    localparam logic [3:0] IDX_MIN_TIM  = 4'd8;
    localparam logic [3:0] IDX_HORA_TIM = 4'd9;
    localparam logic [7:0] ADDR_COM      = 8'hF0;
    localparam logic [7:0] ADDR_SEG      = 8'h21;
    localparam logic [7:0] ADDR_MIN      = 8'h22;
    localparam logic [7:0] ADDR_HORA     = 8'h23;
    localparam logic [7:0] ADDR_DIA      = 8'h24;
    localparam logic [7:0] ADDR_MES      = 8'h25;
    localparam logic [7:0] ADDR_ANIO     = 8'h26;
    localparam logic [7:0] ADDR_SEG_TIM  = 8'h41;
    localparam logic [7:0] ADDR_MIN_TIM  = 8'h42;
    localparam logic [7:0] ADDR_HORA_TIM = 8'h43;
    localparam logic [7:0] CMD_TRANSFER  = 8'hF0;

    function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
        return idx == IDX_COM      ? ADDR_COM      :
               idx == IDX_SEG      ? ADDR_SEG      :
               idx == IDX_MIN      ? ADDR_MIN      :
               idx == IDX_HORA     ? ADDR_HORA     :
               idx == IDX_DIA      ? ADDR_DIA      :
               idx == IDX_MES      ? ADDR_MES      :
               idx == IDX_ANIO     ? ADDR_ANIO     :
               idx == IDX_SEG_TIM  ? ADDR_SEG_TIM  :
               idx == IDX_MIN_TIM  ? ADDR_MIN_TIM  : ADDR_HORA_TIM;
    endfunction
endpackage

// File: rtl/fsm_leer_rtc.sv
// fsm_leer_rtc: bus-cycle sequencer reading the full time/date/timer register set from a multiplexed-bus RTC
module fsm_leer_rtc
    import fsm_leer_rtc_pkg::*;
#(
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 4,
    parameter int T_HOLD   = 1,
    parameter int T_GAP    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic do_it_leer,
    output logic a_d,
    output logic cs,
    output logic rd,
    output logic wr,
    output logic ch0_mux1,
    output logic ch1_mux2,
    output logic dat_lect_seg,
    output logic dat_lect_min,
    output logic dat_lect_hora,
    output logic dat_lect_dia,
    output logic dat_lect_mes,
    output logic dat_lect_anio,
    output logic dat_lect_seg_tim,
    output logic dat_lect_min_tim,
    output logic dat_lect_hora_tim,
    output logic dir_com_cyt,
    output logic dir_seg,
    output logic dir_min,
    output logic dir_hora,
    output logic dir_dia,
    output logic dir_mes,
    output logic dir_anio,
    output logic dir_seg_tim,
    output logic dir_min_tim,
    output logic dir_hora_tim,
    output logic buffer_activo
);
    logic [2:0] state_q, state_d, cnt_q, cnt_d, dur;
    logic       phase_q, phase_d, last;
    logic [3:0] idx_q, idx_d;
    logic       busy, act, strobe, cmd;
    logic [9:0] dir;
    logic [9:1] lect;

    always_comb begin
        dur = state_q == S_SETUP  ? 3'(T_SETUP)  :
              state_q == S_STROBE ? 3'(T_STROBE) :
              state_q == S_HOLD   ? 3'(T_HOLD)   : 3'(T_GAP);
        last    = cnt_q == dur - 3'd1;
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        cnt_d   = last ? 3'd0 : cnt_q + 3'd1;
        case (state_q)
            S_IDLE: begin
                cnt_d   = 3'd0;
                state_d = do_it_leer ? S_SETUP : S_IDLE;
                phase_d = PH_ADDR;
                idx_d   = IDX_COM;
            end
            S_SETUP:  state_d = last ? S_STROBE : S_SETUP;
            S_STROBE: state_d = last ? S_HOLD : S_STROBE;
            S_HOLD:   state_d = last ? S_GAP : S_HOLD;
            S_GAP: if (last) begin
                // ADDR phase rolls into DATA; DATA phase advances the access or ends the burst
                state_d = (phase_q == PH_DATA && idx_q == IDX_HORA_TIM) ? S_IDLE : S_SETUP;
                phase_d = ~phase_q;
                idx_d   = phase_q == PH_DATA ? idx_q + 4'd1 : idx_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= PH_ADDR;
            idx_q   <= IDX_COM;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        busy   = state_q != S_IDLE;
        act    = state_q == S_SETUP || state_q == S_STROBE || state_q == S_HOLD;
        strobe = state_q == S_STROBE;
        cmd    = idx_q == IDX_COM;
        dir    = busy ? 10'(1) << idx_q : 10'd0;
        lect   = (strobe && phase_q == PH_DATA && !cmd && last) ? dir[9:1] : 9'd0;
    end

    assign cs            = ~act;
    assign a_d           = ~(busy && phase_q == PH_ADDR && state_q != S_GAP);
    assign wr            = ~(strobe && (phase_q == PH_ADDR || cmd));
    assign rd            = ~(strobe && phase_q == PH_DATA && !cmd);
    assign ch0_mux1      = act && phase_q == PH_ADDR;
    assign ch1_mux2      = act && phase_q == PH_DATA && cmd;
    assign buffer_activo = ch0_mux1 || ch1_mux2;
    assign {dir_hora_tim, dir_min_tim, dir_seg_tim, dir_anio, dir_mes, dir_dia,
            dir_hora, dir_min, dir_seg, dir_com_cyt} = dir;
    assign {dat_lect_hora_tim, dat_lect_min_tim, dat_lect_seg_tim, dat_lect_anio, dat_lect_mes,
            dat_lect_dia, dat_lect_hora, dat_lect_min, dat_lect_seg} = lect;
endmodule

// File: tb/tb_fsm_leer_rtc.sv
// tb_fsm_leer_rtc: directed scenarios for the RTC read sequencer with hand-computed cycle timing
module tb_fsm_leer_rtc;
    logic clk = 0, reset = 1, do_it_leer = 0;
    logic a_d, cs, rd, wr, ch0_mux1, ch1_mux2, buffer_activo;
    logic dat_lect_seg, dat_lect_min, dat_lect_hora, dat_lect_dia, dat_lect_mes, dat_lect_anio;
    logic dat_lect_seg_tim, dat_lect_min_tim, dat_lect_hora_tim;
    logic dir_com_cyt, dir_seg, dir_min, dir_hora, dir_dia, dir_mes, dir_anio;
    logic dir_seg_tim, dir_min_tim, dir_hora_tim;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fsm_leer_rtc dut (
        .clk(clk), .reset(reset), .do_it_leer(do_it_leer),
        .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
        .ch0_mux1(ch0_mux1), .ch1_mux2(ch1_mux2),
        .dat_lect_seg(dat_lect_seg), .dat_lect_min(dat_lect_min), .dat_lect_hora(dat_lect_hora),
        .dat_lect_dia(dat_lect_dia), .dat_lect_mes(dat_lect_mes), .dat_lect_anio(dat_lect_anio),
        .dat_lect_seg_tim(dat_lect_seg_tim), .dat_lect_min_tim(dat_lect_min_tim),
        .dat_lect_hora_tim(dat_lect_hora_tim),
        .dir_com_cyt(dir_com_cyt), .dir_seg(dir_seg), .dir_min(dir_min), .dir_hora(dir_hora),
        .dir_dia(dir_dia), .dir_mes(dir_mes), .dir_anio(dir_anio), .dir_seg_tim(dir_seg_tim),
        .dir_min_tim(dir_min_tim), .dir_hora_tim(dir_hora_tim),
        .buffer_activo(buffer_activo)
    );

    wire [9:0] dir_v = {dir_hora_tim, dir_min_tim, dir_seg_tim, dir_anio, dir_mes, dir_dia,
                        dir_hora, dir_min, dir_seg, dir_com_cyt};
    wire [9:1] lect_v = {dat_lect_hora_tim, dat_lect_min_tim, dat_lect_seg_tim, dat_lect_anio,
                         dat_lect_mes, dat_lect_dia, dat_lect_hora, dat_lect_min, dat_lect_seg};
    wire [3:0] strobes_v = {a_d, cs, rd, wr};
    wire [2:0] misc_v = {ch0_mux1, ch1_mux2, buffer_activo};

    task automatic do_reset();
        reset = 1;
        do_it_leer = 0;
        repeat (3) @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        do_it_leer = 0;
        repeat (10) @(negedge clk);
        checks++;
        if (strobes_v !== 4'b1111) begin errors++; $display("FAIL reset_strobes got %b want 1111", strobes_v); end
        checks++;
        if (dir_v !== 10'd0) begin errors++; $display("FAIL reset_dir got %b want 0", dir_v); end
        checks++;
        if (lect_v !== 9'd0) begin errors++; $display("FAIL reset_lect got %b want 0", lect_v); end
        checks++;
        if (misc_v !== 3'b000) begin errors++; $display("FAIL reset_misc got %b want 000", misc_v); end
    endtask

    task automatic test_first_access();
        logic [15:0] cs_e, ad_e, wr_e, c0_e, c1_e;
        cs_e = 16'hC0C0; ad_e = 16'hFFC0; wr_e = 16'hE1E1; c0_e = 16'h003F; c1_e = 16'h3F00;
        reset = 1;
        do_it_leer = 1;
        repeat (3) @(negedge clk);
        reset = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            checks++;
            if ({cs, a_d, wr, rd} !== {cs_e[c-1], ad_e[c-1], wr_e[c-1], 1'b1})
                begin errors++; $display("FAIL first_bus c%0d got cs/ad/wr/rd %b want %b", c, {cs, a_d, wr, rd}, {cs_e[c-1], ad_e[c-1], wr_e[c-1], 1'b1}); end
            checks++;
            if ({ch0_mux1, ch1_mux2, buffer_activo} !== {c0_e[c-1], c1_e[c-1], c0_e[c-1] | c1_e[c-1]})
                begin errors++; $display("FAIL first_mux c%0d got %b want %b", c, {ch0_mux1, ch1_mux2, buffer_activo}, {c0_e[c-1], c1_e[c-1], c0_e[c-1] | c1_e[c-1]}); end
            checks++;
            if (dir_v !== 10'd1) begin errors++; $display("FAIL first_dir c%0d got %b want 0000000001", c, dir_v); end
        end
        @(negedge clk);
        checks++;
        if (dir_v !== 10'd2) begin errors++; $display("FAIL second_dir got %b want 0000000010", dir_v); end
        do_it_leer = 0;
    endtask

    task automatic test_burst_single_pulse();
        int n = 0;
        logic [9:1] prev = '0;
        do_reset();
        do_it_leer = 1;
        for (int c = 1; c <= 175; c++) begin
            @(negedge clk);
            if (lect_v !== 9'd0) begin
                n++;
                checks++;
                if (lect_v !== 9'(1) << (n - 1))
                    begin errors++; $display("FAIL burst_order pulse %0d got %b want %b", n, lect_v, 9'(1) << (n - 1)); end
                checks++;
                if (c !== 16 * n + 13) begin errors++; $display("FAIL burst_pos pulse %0d cycle %0d want %0d", n, c, 16 * n + 13); end
                checks++;
                if ({rd, buffer_activo} !== 2'b00) begin errors++; $display("FAIL burst_rd rd/buf %b want 00", {rd, buffer_activo}); end
                checks++;
                if ((prev & lect_v) !== 9'd0) begin errors++; $display("FAIL burst_width got %b twice", lect_v); end
            end
            if (c > 160) begin
                checks++;
                if ({cs, dir_v} !== {1'b1, 10'd0}) begin errors++; $display("FAIL burst_idle c%0d cs %b dir %b want 1 0", c, cs, dir_v); end
            end
            prev = lect_v;
            if (c == 1) do_it_leer = 0;
        end
        checks++;
        if (n !== 9) begin errors++; $display("FAIL burst_count got %0d want 9", n); end
    endtask

    task automatic test_repeat();
        int starts[$];
        logic prev_com = 0;
        do_reset();
        do_it_leer = 1;
        for (int c = 1; c <= 500; c++) begin
            @(negedge clk);
            if (dir_com_cyt && !prev_com) starts.push_back(c);
            prev_com = dir_com_cyt;
            checks++;
            if (!$onehot0(dir_v)) begin errors++; $display("FAIL rep_onehot c%0d dir %b", c, dir_v); end
            checks++;
            if (!rd && !wr) begin errors++; $display("FAIL rep_rdwr c%0d rd and wr both 0", c); end
            checks++;
            if (!rd && buffer_activo) begin errors++; $display("FAIL rep_buf c%0d buffer 1 while rd 0", c); end
            if (c == 431) do_it_leer = 0;
        end
        checks++;
        if (starts.size() !== 3) begin errors++; $display("FAIL rep_bursts got %0d want 3", starts.size()); end
        else begin
            checks++;
            if (starts[0] !== 1) begin errors++; $display("FAIL rep_first got %0d want 1", starts[0]); end
            checks++;
            if (starts[1] - starts[0] !== 161 || starts[2] - starts[1] !== 161)
                begin errors++; $display("FAIL rep_period got %0d,%0d want 161", starts[1] - starts[0], starts[2] - starts[1]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        do_it_leer = 1;
        for (int c = 1; c <= 123; c++) begin
            @(negedge clk);
            if (c == 1) do_it_leer = 0;
        end
        checks++;
        if ({rd, dir_seg_tim} !== 2'b01) begin errors++; $display("FAIL mid_strobe rd/dir %b want 01", {rd, dir_seg_tim}); end
        reset = 1;
        @(negedge clk);
        checks++;
        if ({strobes_v, misc_v, dir_v, lect_v} !== {4'b1111, 3'b000, 10'd0, 9'd0})
            begin errors++; $display("FAIL mid_reset got %b want %b", {strobes_v, misc_v, dir_v, lect_v}, {4'b1111, 3'b000, 10'd0, 9'd0}); end
        reset = 0;
        @(negedge clk);
        checks++;
        if (cs !== 1'b1) begin errors++; $display("FAIL mid_stay_idle cs %b want 1", cs); end
        do_it_leer = 1;
        @(negedge clk);
        do_it_leer = 0;
        checks++;
        if ({dir_v, a_d, cs, ch0_mux1} !== {10'd1, 3'b001})
            begin errors++; $display("FAIL mid_restart got %b want %b", {dir_v, a_d, cs, ch0_mux1}, {10'd1, 3'b001}); end
    endtask

    initial begin
        test_reset();
        test_first_access();
        test_burst_single_pulse();
        test_repeat();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
